// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : writeback_stage_pkg
// Brief  : Shared types, micro-op and condition constants for the writeback path.
// Rev    : 1.0
// ============================================================================
package writeback_stage_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } Flags;

    localparam logic [4:0] c_UOP_NOP = 5'd0;
    localparam logic [4:0] c_UOP_ADD = 5'd1;
    localparam logic [4:0] c_UOP_SUB = 5'd2;
    localparam logic [4:0] c_UOP_AND = 5'd3;
    localparam logic [4:0] c_UOP_EOR = 5'd4;
    localparam logic [4:0] c_UOP_CMP = 5'd5;
    localparam logic [4:0] c_UOP_LSL = 5'd6;
    localparam logic [4:0] c_UOP_LSR = 5'd7;
    localparam logic [4:0] c_UOP_MOV = 5'd8;
    localparam logic [4:0] c_UOP_STR = 5'd9;
    localparam logic [4:0] c_UOP_LDR = 5'd10;

    localparam logic [3:0] c_COND_EQ = 4'd0;
    localparam logic [3:0] c_COND_NE = 4'd1;
    localparam logic [3:0] c_COND_CS = 4'd2;
    localparam logic [3:0] c_COND_CC = 4'd3;
    localparam logic [3:0] c_COND_MI = 4'd4;
    localparam logic [3:0] c_COND_PL = 4'd5;
    localparam logic [3:0] c_COND_VS = 4'd6;
    localparam logic [3:0] c_COND_VC = 4'd7;
    localparam logic [3:0] c_COND_HI = 4'd8;
    localparam logic [3:0] c_COND_LS = 4'd9;
    localparam logic [3:0] c_COND_GE = 4'd10;
    localparam logic [3:0] c_COND_LT = 4'd11;
    localparam logic [3:0] c_COND_GT = 4'd12;
    localparam logic [3:0] c_COND_LE = 4'd13;
    localparam logic [3:0] c_COND_AL = 4'd14;
    localparam logic [3:0] c_COND_NV = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_e;

    function automatic logic is_flag_setting(input logic [4:0] uop);
        logic r;
        r = 1'b0;
        case (uop)
            c_UOP_ADD, c_UOP_SUB, c_UOP_AND, c_UOP_EOR,
            c_UOP_CMP, c_UOP_LSL, c_UOP_LSR, c_UOP_MOV: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Every flag-setting op except CMP also writes its destination register.
    function automatic logic is_reg_write(input logic [4:0] uop);
        return is_flag_setting(uop) && (uop != c_UOP_CMP);
    endfunction

    function automatic logic is_mem_op(input logic [4:0] uop);
        return (uop == c_UOP_STR) || (uop == c_UOP_LDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_stage_cond_check.sv
`default_nettype none
// ============================================================================
// Module : cond_check
// Brief  : Combinational ARM condition-code evaluation against NZCV flags.
// Rev    : 1.0
// ============================================================================
module cond_check
    import writeback_stage_pkg::*;
(
    input  logic [3:0] cond_i,
    input  Flags       flags_i,
    output logic       pass_o
);

    logic w_n_eq_v;

    always_comb begin
        w_n_eq_v = (flags_i.n == flags_i.v);
        pass_o   = 1'b0;
        case (cond_i)
            c_COND_EQ: pass_o = flags_i.z;
            c_COND_NE: pass_o = !flags_i.z;
            c_COND_CS: pass_o = flags_i.c;
            c_COND_CC: pass_o = !flags_i.c;
            c_COND_MI: pass_o = flags_i.n;
            c_COND_PL: pass_o = !flags_i.n;
            c_COND_VS: pass_o = flags_i.v;
            c_COND_VC: pass_o = !flags_i.v;
            c_COND_HI: pass_o = flags_i.c && !flags_i.z;
            c_COND_LS: pass_o = !flags_i.c || flags_i.z;
            c_COND_GE: pass_o = w_n_eq_v;
            c_COND_LT: pass_o = !w_n_eq_v;
            c_COND_GT: pass_o = !flags_i.z && w_n_eq_v;
            c_COND_LE: pass_o = flags_i.z || !w_n_eq_v;
            c_COND_AL: pass_o = 1'b1;
            default:   pass_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module : writeback_stage
// Brief  : Condition check, flag commit, LDR/STR memory handshake, RF write port.
// Rev    : 1.0
// ============================================================================
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int REG_IDX_W   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_uop,
    input  logic [3:0]           in_cond,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [31:0]          in_result,
    input  logic [3:0]           in_flags,
    input  logic [31:0]          in_store_data,
    output logic [3:0]           flags_q,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic                 bus_error
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e                 state_q;
    Flags                   arch_flags_q;
    logic                   rf_we_q;
    logic [REG_IDX_W-1:0]   rf_waddr_q;
    logic [31:0]            rf_wdata_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic                   is_load_q;
    logic [31:0]            mem_addr_q;
    logic [31:0]            mem_wdata_q;
    logic [REG_IDX_W-1:0]   ld_rd_q;
    logic [CNT_W-1:0]       tmo_cnt_q;
    logic                   bus_error_q;

    logic                   w_cond_pass;
    logic                   w_accept;
    logic                   w_timeout;

    cond_check u_cond_check (
        .cond_i  (in_cond),
        .flags_i (arch_flags_q),
        .pass_o  (w_cond_pass)
    );

    // Gated by rst_n so every output reads 0 while reset is held.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign w_accept  = in_valid && in_ready;
    assign w_timeout = (MEM_TIMEOUT != 0) && (tmo_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            arch_flags_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            is_load_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ld_rd_q      <= '0;
            tmo_cnt_q    <= '0;
            bus_error_q  <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept && w_cond_pass) begin
                        if (is_flag_setting(in_uop)) begin
                            arch_flags_q <= Flags'(in_flags);
                        end
                        if (is_reg_write(in_uop)) begin
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= in_rd;
                            rf_wdata_q <= in_result;
                        end
                        if (is_mem_op(in_uop)) begin
                            state_q     <= MEM;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= in_result;
                            mem_we_q    <= (in_uop == c_UOP_STR);
                            is_load_q   <= (in_uop == c_UOP_LDR);
                            mem_wdata_q <= (in_uop == c_UOP_STR) ? in_store_data : 32'd0;
                            ld_rd_q     <= in_rd;
                            tmo_cnt_q   <= '0;
                        end
                    end
                end
                MEM: begin
                    // An ack on the timeout edge still completes normally.
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (is_load_q) begin
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= ld_rd_q;
                            rf_wdata_q <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        bus_error_q <= 1'b1;
                    end else if (MEM_TIMEOUT != 0) begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flags_q   = arch_flags_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_error = bus_error_q;

endmodule
`default_nettype wire
